seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller: shares one 4-bit -> 7-segment decoder across
//  NUM_DIGITS digits. Sequences the digit anodes, presents one 4-bit display code per
//  digit to the decoder, inserts anti-ghosting blank gaps, and blinks selected digits
//  for clock/calendar set mode. Sits between time/date registers and the decoder.
// PARAMETERS
//  NUM_DIGITS    8     digits scanned; >=2
//  DWELL_CYCLES  1000  clk cycles each digit is lit; >=1
//  BLANK_CYCLES  50    clk cycles all anodes off before each digit; >=1
//  BLINK_FRAMES  64    full frames per blink half-period; >=1
// PORTS
//  clk         in   1             system clock, rising edge
//  reset       in   1             synchronous, active-high
//  en          in   1             1 = scan; 0 = display dark, scanner parked
//  digits_in   in   4*NUM_DIGITS  packed codes, digit k = [4k+3:4k]; 4'hF = off
//  blink_mask  in   NUM_DIGITS    1 = digit k blinks
//  hex_out     out  4             code to decoder (4'hF = all segments off)
//  anode_n     out  NUM_DIGITS    active-low digit enables, one-hot-low or all 1
//  frame_done  out  1             1-cycle pulse at end of last digit's SHOW
// BEHAVIOUR
//  - All outputs are registered; decode of state regs, no combinational input paths.
//  - Reset: state=BLANK, idx=0, cnt=0, blink_phase=0, frame_cnt=0, snapshot all 4'hF;
//    hex_out=4'hF, anode_n=all 1, frame_done=0.
//  - FSM states: BLANK, SHOW.
//    BLANK: anode_n=all 1, hex_out=4'hF; lasts exactly BLANK_CYCLES cycles -> SHOW.
//    SHOW: anode_n[idx]=0, others 1; hex_out = (blink_phase & blink_mask[idx]) ? 4'hF
//      : snapshot[idx]; lasts exactly DWELL_CYCLES cycles -> BLANK, idx=idx+1.
//  - idx wraps NUM_DIGITS-1 -> 0; frame = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
//  - Snapshot: digits_in captured on the first cycle of BLANK for idx=0, so a frame
//    never shows mixed old/new values (no tearing). Changes mid-frame are ignored
//    until the next frame.
//  - blink_mask sampled live each SHOW cycle (not snapshotted).
//  - frame_done=1 for the one cycle in which SHOW of idx=NUM_DIGITS-1 leaves.
//    frame_cnt increments then; at BLINK_FRAMES-1 it wraps to 0, blink_phase toggles.
//  - en=0 (any cycle, any state): next cycle state=BLANK, idx=0, cnt=0, all anodes
//    off, hex_out=4'hF, frame_done=0; frame_cnt and blink_phase hold. en 0->1:
//    scan restarts at BLANK/idx 0 with a fresh snapshot on the first enabled cycle.
//  - reset has priority over en; reset mid-SHOW drives anodes off on the next edge.
//  - Invariant: never more than one anode_n bit low; anodes never change in the same
//    cycle hex_out changes to a new lit digit (BLANK always separates digits).
//  - cnt width = $clog2(max(DWELL_CYCLES,BLANK_CYCLES)); frame_cnt width =
//    $clog2(BLINK_FRAMES)+1; no overflow permitted.
// TESTING  (NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2, BLINK_FRAMES=2)
//  1 Reset held 3 cycles -> anode_n=4'b1111, hex_out=F, frame_done=0 throughout.
//  2 en=1, digits_in=16'h4321, mask=0 -> per digit: 2 cycles all-off, then 4 cycles
//    anode_n=1110/1101/1011/0111 with hex_out=1/2/3/4; frame_done pulses every 24 cycles.
//  3 Change digits_in to 16'h9876 during digit 1's SHOW -> frame finishes with 3,4;
//    next frame shows 6,7,8,9.
//  4 blink_mask=4'b0010 -> digit 1 shows F for frames 2-3, real code frames 0-1, 4-5;
//    anode_n[1] still pulses low; other digits unaffected.
//  5 en dropped mid-SHOW of digit 2 -> next cycle anode_n=1111, hex_out=F; en
//    re-raised -> 2 BLANK cycles then digit 0 lit with newly captured code.
//  6 Every cycle of all tests: popcount(~anode_n)<=1; assert reset mid-frame ->
//    reset values next cycle, scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: sequences digit anodes with blank gaps,
// presents one frame-stable 4-bit code per digit and blinks masked digits.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 50,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic [4*NUM_DIGITS-1:0] i_digits_in,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  output logic [3:0]              o_hex_out,
  output logic [NUM_DIGITS-1:0]   o_anode_n,
  output logic                    o_frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int FRM_W   = $clog2(BLINK_FRAMES) + 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [FRM_W-1:0] r_frameCnt;
  logic             r_blinkPhase;
  logic [3:0]       r_snap [NUM_DIGITS];

  state_t                w_stateNext;
  logic [IDX_W-1:0]      w_idxNext;
  logic [CNT_W-1:0]      w_cntNext;
  logic                  w_frameEnd;
  logic                  w_capture;
  logic [3:0]            w_snapNext [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_anodeNext;
  logic [3:0]            w_hexNext;
  logic                  w_frameDoneNext;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_BLANK;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Outputs are computed from the next state so the registered outputs line up with it.
  always_comb begin
    w_stateNext     = r_state;
    w_idxNext       = r_idx;
    w_cntNext       = r_cnt + CNT_W'(1);
    w_frameEnd      = 1'b0;
    w_capture       = 1'b0;
    w_anodeNext     = '1;
    w_hexNext       = 4'hF;
    w_frameDoneNext = 1'b0;

    if (!i_en) begin
      w_stateNext = ST_BLANK;
      w_idxNext   = '0;
      w_cntNext   = '0;
    end else begin
      w_capture = (r_state == ST_BLANK) && (r_idx == '0) && (r_cnt == '0);
      case (r_state)
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_stateNext = ST_SHOW;
            w_cntNext   = '0;
          end
        end
        ST_SHOW: begin
          if (r_cnt == DWELL_LAST) begin
            w_stateNext = ST_BLANK;
            w_cntNext   = '0;
            w_idxNext   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            w_frameEnd  = (r_idx == IDX_LAST);
          end
        end
        default: begin
          w_stateNext = ST_BLANK;
          w_idxNext   = '0;
          w_cntNext   = '0;
        end
      endcase
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_snapNext[k] = w_capture ? i_digits_in[4*k +: 4] : r_snap[k];
    end

    if (w_stateNext == ST_SHOW) begin
      w_anodeNext[w_idxNext] = 1'b0;
      w_hexNext = (r_blinkPhase && i_blink_mask[w_idxNext]) ? 4'hF : w_snapNext[w_idxNext];
      w_frameDoneNext = (w_idxNext == IDX_LAST) && (w_cntNext == DWELL_LAST);
    end
  end

  // Whole-frame snapshot keeps a frame from mixing old and new digit values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_snap[k] <= 4'hF;
      end
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_snap[k] <= w_snapNext[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frameCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (w_frameEnd) begin
      if (r_frameCnt == FRM_LAST) begin
        r_frameCnt   <= '0;
        r_blinkPhase <= ~r_blinkPhase;
      end else begin
        r_frameCnt <= r_frameCnt + FRM_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_anode_n    <= '1;
      o_hex_out    <= 4'hF;
      o_frame_done <= 1'b0;
    end else begin
      o_anode_n    <= w_anodeNext;
      o_hex_out    <= w_hexNext;
      o_frame_done <= w_frameDoneNext;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with a 4-digit, short-timing setup.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int BF = 2;
  localparam int SLOT = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] digitsIn;
  logic [3:0]  blinkMask;
  logic [3:0]  hexOut;
  logic [3:0]  anodeN;
  logic        frameDone;

  int vecCount  = 0;
  int missCount = 0;
  bit benchDone = 1'b0;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL),
    .BLINK_FRAMES(BF)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_en        (en),
    .i_digits_in (digitsIn),
    .i_blink_mask(blinkMask),
    .o_hex_out   (hexOut),
    .o_anode_n   (anodeN),
    .o_frame_done(frameDone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [15:0] d, input logic [3:0] m);
    en        = e;
    digitsIn  = d;
    blinkMask = m;
  endtask

  task automatic checkDark(input string tag);
    checkOutput({tag, " anode"}, anodeN, 4'b1111);
    checkOutput({tag, " hex"}, hexOut, 4'hF);
    checkOutput({tag, " fdone"}, frameDone, 1'b0);
  endtask

  // Walks nCycles of a frame starting at its first BLANK cycle; optionally swaps digitsIn.
  task automatic expectFrame(input string tag, input logic [15:0] codes,
                             input logic [3:0] blanked, input int nCycles,
                             input int changeCycle, input logic [15:0] newDigits);
    for (int c = 0; c < nCycles; c++) begin
      int k;
      int p;
      logic [3:0] expAn;
      logic [3:0] expHex;
      logic       expFd;
      k = c / SLOT;
      p = c % SLOT;
      if (p < BL) begin
        expAn  = 4'b1111;
        expHex = 4'hF;
        expFd  = 1'b0;
      end else begin
        expAn  = ~(4'b0001 << k);
        expHex = blanked[k] ? 4'hF : codes[4*k +: 4];
        expFd  = (k == ND - 1) && (p == SLOT - 1);
      end
      checkOutput($sformatf("%s c%0d anode", tag, c), anodeN, expAn);
      checkOutput($sformatf("%s c%0d hex", tag, c), hexOut, expHex);
      checkOutput($sformatf("%s c%0d fdone", tag, c), frameDone, expFd);
      if (c == changeCycle) digitsIn = newDigits;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (!benchDone) checkOutput("onehot", ($countones(~anodeN) <= 1), 1'b1);
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 16'h4321, 4'b0000);
    repeat (3) begin
      @(negedge clk);
      checkDark("reset");
    end
    reset = 1'b0;

    expectFrame("scan f0", 16'h4321, 4'b0000, FRAME, -1, 16'h0);
    expectFrame("scan f1", 16'h4321, 4'b0000, FRAME, -1, 16'h0);

    expectFrame("snap f0", 16'h4321, 4'b0000, FRAME, 9, 16'h9876);
    expectFrame("snap f1", 16'h9876, 4'b0000, FRAME, -1, 16'h0);

    reset = 1'b1;
    applyStimulus(1'b1, 16'h4321, 4'b0010);
    @(negedge clk);
    reset = 1'b0;
    for (int f = 0; f < 6; f++) begin
      expectFrame($sformatf("blink f%0d", f), 16'h4321,
                  (f == 2 || f == 3) ? 4'b0010 : 4'b0000, FRAME, -1, 16'h0);
    end

    blinkMask = 4'b0000;
    expectFrame("en pre", 16'h4321, 4'b0000, 2 * SLOT + BL + 1, -1, 16'h0);
    checkOutput("en lit anode", anodeN, 4'b1011);
    checkOutput("en lit hex", hexOut, 4'h3);
    applyStimulus(1'b0, 16'h1357, 4'b0000);
    repeat (3) begin
      @(negedge clk);
      checkDark("en off");
    end
    en = 1'b1;
    expectFrame("en back", 16'h1357, 4'b0000, FRAME, -1, 16'h0);

    blinkMask = 4'b0010;
    expectFrame("held phase", 16'h1357, 4'b0010, SLOT + BL + 2, -1, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    checkDark("mid reset");
    reset = 1'b0;
    for (int f = 0; f < 3; f++) begin
      expectFrame($sformatf("post reset f%0d", f), 16'h1357,
                  (f == 2) ? 4'b0010 : 4'b0000, FRAME, -1, 16'h0);
    end

    benchDone = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
